wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter with round-robin fairness and a bus-timeout watchdog.
- Sits in front of a single shared slave (e.g. sram0) so the LM32 data port and a second master (DMA or video fetch) can share it without going through the full interconnect.
- The grant is locked for the whole cycle (cyc high), so bursts and read-modify-write sequences are atomic.

Parameters:
adr_width, 32, address width on all ports
dat_width, 32, data width on all ports; sel width = dat_width/8
timeout, 255, slave wait cycles before an error is forced; 0 disables the watchdog

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m0_adr_i / m1_adr_i  in  adr_width  master address
m0_dat_i / m1_dat_i  in  dat_width  master write data
m0_dat_o / m1_dat_o  out  dat_width  read data returned to master
m0_sel_i / m1_sel_i  in  dat_width/8  byte selects
m0_we_i / m1_we_i  in  1  write enable
m0_cyc_i / m1_cyc_i  in  1  cycle valid
m0_stb_i / m1_stb_i  in  1  strobe
m0_ack_o / m1_ack_o  out  1  acknowledge
m0_err_o / m1_err_o  out  1  error (timeout)
s_adr_o  out  adr_width  slave address
s_dat_o  out  dat_width  slave write data
s_dat_i  in  dat_width  slave read data
s_sel_o  out  dat_width/8  slave byte selects
s_we_o  out  1  slave write enable
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_ack_i  in  1  slave acknowledge
s_err_i  in  1  slave error
gnt_o  out  2  one-hot current grant (debug/probe)

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, gnt_o=0, last=1 (so m0 wins first).
  - s_cyc_o=0, s_stb_o=0, s_we_o=0; all m*_ack_o=0, m*_err_o=0; timeout counter=0.
- Request: req_x = mx_cyc_i & mx_stb_i.
- States: IDLE, G0, G1, TERR, DRAIN.
- IDLE:
  - If exactly one req_x, go to Gx at the next edge.
  - If both request, grant the master != last.
  - Arbitration costs one cycle; the slave sees stb one cycle after the master raises it.
- Gx (grant held):
  - s_adr/dat/sel/we/cyc/stb = master x signals, combinationally.
  - mx_dat_o=s_dat_i, mx_ack_o=s_ack_i, mx_err_o=s_err_i, all combinational (zero added latency in data phase).
  - Non-granted master sees ack=0, err=0, dat_o=0.
  - last<=x on entry.
  - Leave when mx_cyc_i=0. If the other master is requesting in that same cycle, go directly to Gy (no IDLE bubble); else go to IDLE.
- Watchdog (timeout!=0):
  - Counter increments each cycle in Gx with s_stb_o & ~s_ack_i & ~s_err_i.
  - Counter clears on ack, err, or state change.
  - When counter==timeout-1 and still no ack: go to TERR.
- TERR (1 cycle):
  - mx_err_o=1 and s_cyc_o=s_stb_o=0.
  - Then go to DRAIN.
- DRAIN:
  - s_cyc_o=0; wait for mx_cyc_i=0, then go to IDLE.
  - A slave ack arriving late in TERR/DRAIN is discarded, never forwarded.
- Simultaneous events:
  - Ack in the same cycle the counter hits its limit: ack wins, no error.
  - Master dropping cyc in the same cycle as ack: normal release.
- Sub-word widths: pure pass-through, no data manipulation.
- Reset mid-cycle: all outputs go to reset values immediately (asynchronous); the slave may be left mid-transfer, which is acceptable.

Decomposition:
- Package wb_arb_pkg holds:
  - State encoding constants (IDLE=0, G0=1, G1=2, TERR=3, DRAIN=4; 3 bits).
  - Master index constants M0=0, M1=1.
- One natural sub-module, wb_arb_watchdog: counter, clear/enable inputs, expire output, parameter timeout.
- Muxing and FSM stay in the top.

Test Plan:
- Single master: m0 reads 0x80000010 with slave ack on the 2nd stb cycle.
  - gnt_o=01 one cycle after req, m0_ack_o pulses once, m0_dat_o=s_dat_i=0xDEADBEEF.
- Contention: both masters raise cyc/stb in the same cycle after reset.
  - m0 is served first; m1 is granted in the cycle m0_cyc drops (no IDLE cycle).
  - Next simultaneous request: m1 is served first.
- Locked burst: m1 does 4 back-to-back acked transfers with cyc held high while m0 requests.
  - m0 gets no grant until m1_cyc=0; gnt_o stays 10 for all 4 acks.
- Timeout: timeout=8, slave never acks m0.
  - m0_err_o pulses exactly 8 cycles after s_stb_o rises, s_cyc_o drops in the same cycle, and the state waits in DRAIN until m0_cyc=0.
  - A late s_ack_i=1 during DRAIN is not seen on m0_ack_o.
- Reset mid-transfer: reset_n low while in G0 with s_stb_o high.
  - s_cyc_o/s_stb_o/gnt_o go to 0 without a clock edge.
  - After release, m0 is granted first again.
- Ack-vs-timeout race: timeout=4 with ack on the 4th wait cycle.
  - m0_ack_o=1, m0_err_o=0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared encodings for the two-master round-robin Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    G0    = 3'd1,
    G1    = 3'd2,
    TERR  = 3'd3,
    DRAIN = 3'd4
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Slave wait-state counter; flags expiry on the last wait cycle that has
// no ack, so the owner FSM can force an error on the next edge.
module wb_arb_watchdog #(
  parameter int timeout = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int CW = (timeout > 1) ? $clog2(timeout) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(timeout - 1);
  localparam bit ENABLED = (timeout != 0);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear takes priority so an ack in a wait cycle never counts.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // inc_i already excludes ack/err, so an ack on the limit cycle wins.
  assign expire_o = ENABLED && inc_i && (cnt_q == LIMIT);

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master / one-slave Wishbone arbiter. Grant is locked for the whole
// cyc, handed over without an idle bubble, and a stuck slave is cut off
// by the watchdog (error to the owner, then drain until it drops cyc).
module wb_rr_arbiter import wb_arb_pkg::*; #(
  parameter int adr_width = 32,
  parameter int dat_width = 32,
  parameter int timeout   = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [adr_width-1:0]   m0_adr_i,
  input  logic [dat_width-1:0]   m0_dat_i,
  output logic [dat_width-1:0]   m0_dat_o,
  input  logic [dat_width/8-1:0] m0_sel_i,
  input  logic                   m0_we_i,
  input  logic                   m0_cyc_i,
  input  logic                   m0_stb_i,
  output logic                   m0_ack_o,
  output logic                   m0_err_o,
  input  logic [adr_width-1:0]   m1_adr_i,
  input  logic [dat_width-1:0]   m1_dat_i,
  output logic [dat_width-1:0]   m1_dat_o,
  input  logic [dat_width/8-1:0] m1_sel_i,
  input  logic                   m1_we_i,
  input  logic                   m1_cyc_i,
  input  logic                   m1_stb_i,
  output logic                   m1_ack_o,
  output logic                   m1_err_o,
  output logic [adr_width-1:0]   s_adr_o,
  output logic [dat_width-1:0]   s_dat_o,
  input  logic [dat_width-1:0]   s_dat_i,
  output logic [dat_width/8-1:0] s_sel_o,
  output logic                   s_we_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  output logic [1:0]             gnt_o
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;   // last granted master; also the current owner
  logic       req0, req1, granted, own_cyc, oth_req;
  logic       wd_inc, wd_clr, wd_expire;

  assign req0    = m0_cyc_i & m0_stb_i;
  assign req1    = m1_cyc_i & m1_stb_i;
  assign granted = (state_q == G0) || (state_q == G1);
  assign own_cyc = (last_q == M1) ? m1_cyc_i : m0_cyc_i;
  assign oth_req = (last_q == M1) ? req0 : req1;

  // Arbitration and bus-cycle ownership.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          last_d  = ~last_q;
          state_d = (last_q == M1) ? G0 : G1;
        end else if (req0) begin
          last_d  = M0;
          state_d = G0;
        end else if (req1) begin
          last_d  = M1;
          state_d = G1;
        end
      end
      G0, G1: begin
        if (!own_cyc) begin
          if (oth_req) begin
            last_d  = ~last_q;
            state_d = (last_q == M1) ? G0 : G1;
          end else begin
            state_d = IDLE;
          end
        end else if (wd_expire) begin
          state_d = TERR;
        end
      end
      TERR:    state_d = DRAIN;
      DRAIN:   if (!own_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and round-robin pointer; m0 wins the first contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= M1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Zero-latency pass-through for the owner; late slave responses outside
  // a grant are swallowed.
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_dat_o = '0;
    m1_dat_o = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    if (granted) begin
      if (last_q == M1) begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i;
      end else begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i;
      end
    end else if (state_q == TERR) begin
      if (last_q == M1) m1_err_o = 1'b1;
      else              m0_err_o = 1'b1;
    end
  end

  assign gnt_o = (state_q == IDLE) ? 2'b00 : ((last_q == M1) ? 2'b10 : 2'b01);

  assign wd_inc = granted & s_stb_o & ~s_ack_i & ~s_err_i;
  assign wd_clr = s_ack_i | s_err_i | (state_d != state_q);

  wb_arb_watchdog #(.timeout(timeout)) u_wdog (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .inc_i    (wd_inc),
    .clr_i    (wd_clr),
    .expire_o (wd_expire)
  );

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench: u_dut uses timeout=8, u_dut4 (same stimulus) timeout=4
// for the ack-versus-timeout race.
module tb_wb_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] m0_adr, m1_adr, m0_dat, m1_dat, s_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb, s_ack, s_err;

  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, s_we_o, s_cyc_o, s_stb_o;
  logic [1:0]  gnt_o;

  logic [31:0] w4_m0_dat_o, w4_m1_dat_o, w4_s_adr_o, w4_s_dat_o;
  logic [3:0]  w4_s_sel_o;
  logic        w4_m0_ack_o, w4_m1_ack_o, w4_m0_err_o, w4_m1_err_o;
  logic        w4_s_we_o, w4_s_cyc_o, w4_s_stb_o;
  logic [1:0]  w4_gnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.adr_width(32), .dat_width(32), .timeout(8)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel),
    .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel),
    .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack), .s_err_i(s_err), .gnt_o(gnt_o)
  );

  wb_rr_arbiter #(.adr_width(32), .dat_width(32), .timeout(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(w4_m0_dat_o), .m0_sel_i(m0_sel),
    .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(w4_m0_ack_o), .m0_err_o(w4_m0_err_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(w4_m1_dat_o), .m1_sel_i(m1_sel),
    .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(w4_m1_ack_o), .m1_err_o(w4_m1_err_o),
    .s_adr_o(w4_s_adr_o), .s_dat_o(w4_s_dat_o), .s_dat_i(s_dat), .s_sel_o(w4_s_sel_o), .s_we_o(w4_s_we_o),
    .s_cyc_o(w4_s_cyc_o), .s_stb_o(w4_s_stb_o), .s_ack_i(s_ack), .s_err_i(s_err), .gnt_o(w4_gnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns just after the rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req0(input logic v);
    m0_cyc = v;
    m0_stb = v;
  endtask

  task automatic req1(input logic v);
    m1_cyc = v;
    m1_stb = v;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    m0_adr = 32'h8000_0010; m1_adr = 32'h4000_0020;
    m0_dat = 32'h1111_1111; m1_dat = 32'h2222_2222;
    m0_sel = 4'hF;          m1_sel = 4'h3;
    s_dat = '0; s_ack = 1'b0; s_err = 1'b0;
    m0_we = 1'b1; m1_we = 1'b0;
    req0(1'b1); req1(1'b0);

    // Reset state, with m0 requesting to show nothing leaks through.
    step(); step();
    #1;
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_cyc", 32'(s_cyc_o), 32'd0);
    chk("rst_stb", 32'(s_stb_o), 32'd0);
    chk("rst_we", 32'(s_we_o), 32'd0);
    chk("rst_ack_err", {28'd0, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 32'd0);
    req0(1'b0); m0_we = 1'b0;
    reset_n = 1'b1;

    // Single master read, slave acks on 2nd stb cycle.
    step(); req0(1'b1);
    #1; chk("sm_arb_gnt", 32'(gnt_o), 32'd0);
    chk("sm_arb_stb", 32'(s_stb_o), 32'd0);
    step();
    #1; chk("sm_gnt", 32'(gnt_o), 32'd1);
    chk("sm_adr", s_adr_o, 32'h8000_0010);
    chk("sm_ack_wait", 32'(m0_ack_o), 32'd0);
    step(); s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
    #1; chk("sm_ack", 32'(m0_ack_o), 32'd1);
    chk("sm_dat", m0_dat_o, 32'hDEAD_BEEF);
    chk("sm_m1_quiet", {m1_dat_o[30:0], m1_ack_o}, 32'd0);
    step(); s_ack = 1'b0; req0(1'b0);
    #1; chk("sm_ack_pulse", 32'(m0_ack_o), 32'd0);
    chk("sm_cyc_drop", 32'(s_cyc_o), 32'd0);
    step();
    #1; chk("sm_idle", 32'(gnt_o), 32'd0);

    // Contention after m0 was last served: m1 first, m0 handed over.
    step(); req0(1'b1); req1(1'b1);
    #1; chk("ct_arb", 32'(gnt_o), 32'd0);
    step(); s_ack = 1'b1;
    #1; chk("ct_m1_first", 32'(gnt_o), 32'd2);
    chk("ct_m1_adr", s_adr_o, 32'h4000_0020);
    chk("ct_m1_sel", 32'(s_sel_o), 32'h3);
    chk("ct_m1_ack", {30'd0, m1_ack_o, m0_ack_o}, 32'd2);
    step(); s_ack = 1'b0; req1(1'b0);
    #1; chk("ct_m1_hold", 32'(gnt_o), 32'd2);
    step(); s_ack = 1'b1;
    #1; chk("ct_handover", 32'(gnt_o), 32'd1);
    chk("ct_m0_ack", {30'd0, m1_ack_o, m0_ack_o}, 32'd1);
    step(); s_ack = 1'b0; req0(1'b0);
    step();
    #1; chk("ct_idle", 32'(gnt_o), 32'd0);

    // Reset mid-transfer, then contention out of reset: m0 first.
    step(); req0(1'b1);
    step();
    #1; chk("rm_stb_before", 32'(s_stb_o), 32'd1);
    #2; reset_n = 1'b0; req1(1'b1);
    #1; chk("rm_async", {29'd0, s_cyc_o, gnt_o}, 32'd0);
    chk("rm_async_stb", 32'(s_stb_o), 32'd0);
    step(); step(); reset_n = 1'b1;
    step(); s_ack = 1'b1;
    #1; chk("rm_m0_first", 32'(gnt_o), 32'd1);
    chk("rm_m0_ack", 32'(m0_ack_o), 32'd1);
    step(); s_ack = 1'b0; req0(1'b0);
    step(); s_ack = 1'b1;
    #1; chk("rm_handover", 32'(gnt_o), 32'd2);
    step(); s_ack = 1'b0; req1(1'b0);
    step();

    // Locked burst: m1 holds cyc through 4 acks while m0 waits.
    step(); req1(1'b1);
    step(); req0(1'b1); m1_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_ack = 1'b1;
      #1; chk("lb_gnt", 32'(gnt_o), 32'd2);
      chk("lb_acks", {30'd0, m1_ack_o, m0_ack_o}, 32'd2);
      chk("lb_wdat", s_dat_o, 32'h2222_2222);
      step();
    end
    s_ack = 1'b0; req1(1'b0); m1_we = 1'b0;
    #1; chk("lb_last_cycle", 32'(gnt_o), 32'd2);
    step();
    #1; chk("lb_to_m0", 32'(gnt_o), 32'd1);
    req0(1'b0);
    step(); step();

    // Watchdog: slave never acks, error 8 cycles after stb rises.
    req0(1'b1);
    step();
    for (int i = 0; i < 8; i++) begin
      #1; chk("to_wait", {30'd0, s_stb_o, m0_err_o}, 32'd2);
      step();
    end
    #1; chk("to_err", 32'(m0_err_o), 32'd1);
    chk("to_cut", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
    step(); s_ack = 1'b1; req1(1'b1);
    #1; chk("to_late_ack", {30'd0, m0_ack_o, m0_err_o}, 32'd0);
    chk("to_drain_cyc", 32'(s_cyc_o), 32'd0);
    step(); s_ack = 1'b0;
    #1; chk("to_drain_hold", 32'(s_cyc_o), 32'd0);
    req0(1'b0);
    step();
    #1; chk("to_idle", 32'(gnt_o), 32'd0);
    step();
    #1; chk("to_m1_after", 32'(gnt_o), 32'd2);
    req1(1'b0);
    step(); step();

    // Ack on the 4th wait cycle with timeout=4: ack wins.
    reset_n = 1'b0;
    step(); reset_n = 1'b1;
    step(); req0(1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      #1; chk("race_wait", 32'(w4_m0_err_o), 32'd0);
      step();
    end
    s_ack = 1'b1;
    #1; chk("race_ack", {30'd0, w4_m0_ack_o, w4_m0_err_o}, 32'd2);
    step(); s_ack = 1'b0; req0(1'b0);
    #1; chk("race_no_terr", 32'(w4_m0_err_o), 32'd0);
    step();
    #1; chk("race_idle", 32'(w4_gnt_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
